// File: rtl/ddr3_dfi_responder_pkg.sv
// ddr3_dfi_responder_pkg: DDR3 command encodings, burst length, bank count and queue depth
// shared by the DFI responder and its command queues.
package ddr3_dfi_responder_pkg;
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;
  localparam int BURST_LEN   = 4;
  localparam int NUM_BANKS   = 8;
  localparam int BANK_BITS   = 3;
  localparam int QUEUE_DEPTH = 4;
endpackage

// File: rtl/ddr3_dfi_cmdq.sv
// ddr3_dfi_cmdq: small synchronous FIFO holding burst base addresses.
//   clock/reset_n : clock, asynchronous active-low reset
//   push_i/data_i : enqueue (ignored when full)
//   pop_i         : dequeue head (ignored when empty)
//   data_o        : current head entry
//   full_o/empty_o: occupancy flags
module ddr3_dfi_cmdq #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rp_q];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wp_q] <= data_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (pop_ok) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/ddr3_dfi_responder.sv
// ddr3_dfi_responder: terminates a DFI command/data interface in place of PHY + DDR3 device.
//   clock/reset_n            : clock, asynchronous active-low reset
//   dfi_cke_i..dfi_we_ni     : command bus (decoded only with cke=1, cs_n=0)
//   dfi_bank_i/dfi_addr_i    : bank, row (ACT) or column (RD/WR), addr[10] = all banks on PRE
//   dfi_wren_i/mask/data_i   : write beats (mask bit 1 = byte kept)
//   dfi_wstb_i, dfi_rden_i   : accepted but unused
//   dfi_rvld_o/last_o/data_o : read beats, RD_LATENCY cycles after RD
//   err_o                    : sticky protocol-error flag
module ddr3_dfi_responder
  import ddr3_dfi_responder_pkg::*;
#(
  parameter int DDR_ROW_BITS  = 15,
  parameter int DDR_COL_BITS  = 10,
  parameter int DFI_DQ_WIDTH  = 32,
  parameter int DFI_DM_WIDTH  = 4,
  parameter int MEM_ADDR_BITS = 10,
  parameter int RD_LATENCY    = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    dfi_cke_i,
  input  logic                    dfi_cs_ni,
  input  logic                    dfi_ras_ni,
  input  logic                    dfi_cas_ni,
  input  logic                    dfi_we_ni,
  input  logic [BANK_BITS-1:0]    dfi_bank_i,
  input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
  input  logic                    dfi_wstb_i,
  input  logic                    dfi_wren_i,
  input  logic [DFI_DM_WIDTH-1:0] dfi_mask_i,
  input  logic [DFI_DQ_WIDTH-1:0] dfi_data_i,
  input  logic                    dfi_rden_i,
  output logic                    dfi_rvld_o,
  output logic                    dfi_last_o,
  output logic [DFI_DQ_WIDTH-1:0] dfi_data_o,
  output logic                    err_o
);
  // Stages between RD decode and the burst queue; one cycle of queue and one of
  // RAM read make up the rest of the latency.
  localparam int DLY    = RD_LATENCY - 2;
  localparam int FULL_W = BANK_BITS + DDR_ROW_BITS + DDR_COL_BITS - 3 + 2;
  logic                     cmd_v, is_act, is_rd, is_wr, is_pre, is_ref;
  cmd_e                     cmd;
  logic [NUM_BANKS-1:0]     open_q, open_d;
  logic [DDR_ROW_BITS-1:0]  row_q [NUM_BANKS];
  logic                     bank_open;
  logic [FULL_W-1:0]        full_addr;
  logic [MEM_ADDR_BITS-1:0] cmd_base;
  logic                     rd_ok, wr_ok, wr_beat;
  logic                     wq_full, wq_empty;
  logic [MEM_ADDR_BITS-1:0] wq_head, wr_addr;
  logic [1:0]               wbeat_q, wbeat_d;
  logic                     dl_push;
  logic [MEM_ADDR_BITS-1:0] dl_addr;
  logic                     rq_full, rq_empty, rq_issue;
  logic [MEM_ADDR_BITS-1:0] rq_head, rd_addr;
  logic [1:0]               rbeat_q, rbeat_d;
  logic                     err_d, err_q, rvld_q, last_q;
  logic [DFI_DQ_WIDTH-1:0]  data_q;
  logic [DFI_DQ_WIDTH-1:0]  mem [2**MEM_ADDR_BITS];
  logic                     unused;
  assign cmd_v     = dfi_cke_i & ~dfi_cs_ni;
  assign cmd       = cmd_e'({dfi_ras_ni, dfi_cas_ni, dfi_we_ni});
  assign is_act    = cmd_v && (cmd == CMD_ACT);
  assign is_rd     = cmd_v && (cmd == CMD_RD);
  assign is_wr     = cmd_v && (cmd == CMD_WR);
  assign is_pre    = cmd_v && (cmd == CMD_PRE);
  assign is_ref    = cmd_v && (cmd == CMD_REF);
  assign bank_open = open_q[dfi_bank_i];
  // col[2:0] selects within the BL8 burst and is dropped; beat index fills the low two bits.
  assign full_addr = {dfi_bank_i, row_q[dfi_bank_i], dfi_addr_i[DDR_COL_BITS-1:3], 2'b00};
  assign cmd_base  = full_addr[MEM_ADDR_BITS-1:0];
  assign rd_ok     = is_rd & bank_open;
  assign wr_ok     = is_wr & bank_open & ~wq_full;
  assign wr_beat   = dfi_wren_i & ~wq_empty;
  assign wr_addr   = wq_head | MEM_ADDR_BITS'(wbeat_q);
  assign rq_issue  = ~rq_empty;
  assign rd_addr   = rq_head | MEM_ADDR_BITS'(rbeat_q);
  assign unused    = ^{dfi_wstb_i, dfi_rden_i, full_addr[FULL_W-1:MEM_ADDR_BITS]};
  assign dfi_rvld_o = rvld_q;
  assign dfi_last_o = last_q;
  assign dfi_data_o = data_q;
  assign err_o      = err_q;
  always_comb begin
    open_d  = open_q;
    wbeat_d = wr_beat ? wbeat_q + 2'd1 : wbeat_q;
    rbeat_d = rq_issue ? rbeat_q + 2'd1 : rbeat_q;
    err_d   = ((is_rd | is_wr) & ~bank_open) | (is_act & bank_open) | (is_ref & |open_q)
            | (dfi_wren_i & wq_empty) | (is_wr & wq_full) | (dl_push & rq_full);
    if (is_act) open_d[dfi_bank_i] = 1'b1;
    if (is_pre) open_d = dfi_addr_i[10] ? '0 : open_q & ~(NUM_BANKS'(1) << dfi_bank_i);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      open_q  <= '0;
      wbeat_q <= '0;
      rbeat_q <= '0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else begin
      open_q  <= open_d;
      wbeat_q <= wbeat_d;
      rbeat_q <= rbeat_d;
      err_q   <= err_q | err_d;
      rvld_q  <= rq_issue;
      last_q  <= rq_issue & (rbeat_q == 2'd3);
      if (rq_issue) data_q <= mem[rd_addr];
      if (is_act & ~bank_open) row_q[dfi_bank_i] <= dfi_addr_i;
    end
  end
  // Contents are deliberately not reset; same-cycle read of a written word sees the old value.
  always_ff @(posedge clock) begin
    if (wr_beat)
      for (int b = 0; b < DFI_DM_WIDTH; b++)
        if (!dfi_mask_i[b]) mem[wr_addr][8*b +: 8] <= dfi_data_i[8*b +: 8];
  end
  generate
    if (DLY == 0) begin : g_nodly
      assign dl_push = rd_ok;
      assign dl_addr = cmd_base;
    end else begin : g_dly
      logic [DLY-1:0]           v_q;
      logic [MEM_ADDR_BITS-1:0] a_q [DLY];
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          v_q <= '0;
          for (int i = 0; i < DLY; i++) a_q[i] <= '0;
        end else begin
          v_q[0] <= rd_ok;
          a_q[0] <= cmd_base;
          for (int i = 1; i < DLY; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
          end
        end
      end
      assign dl_push = v_q[DLY-1];
      assign dl_addr = a_q[DLY-1];
    end
  endgenerate
  ddr3_dfi_cmdq #(.W(MEM_ADDR_BITS), .DEPTH(QUEUE_DEPTH)) u_wq (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (wr_ok),
    .data_i  (cmd_base),
    .pop_i   (wr_beat && (wbeat_q == 2'd3)),
    .data_o  (wq_head),
    .full_o  (wq_full),
    .empty_o (wq_empty)
  );
  ddr3_dfi_cmdq #(.W(MEM_ADDR_BITS), .DEPTH(QUEUE_DEPTH)) u_rq (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (dl_push),
    .data_i  (dl_addr),
    .pop_i   (rq_issue && (rbeat_q == 2'd3)),
    .data_o  (rq_head),
    .full_o  (rq_full),
    .empty_o (rq_empty)
  );
endmodule
